// File: rtl/mem_reg_fifo_if.sv
// mem_reg_fifo_if: push/pop, status and control signals of the memory staging FIFO
interface mem_reg_fifo_if #(parameter int W = 8, parameter int D = 4);
  localparam int AW = $clog2(D);
  logic          Flush;
  logic          WriteEn;
  logic [W-1:0]  DataIn;
  logic          ReadEn;
  logic          ClearErr;
  logic [W-1:0]  DataOut;
  logic          Empty;
  logic          Full;
  logic [AW:0]   Count;
  logic          Overflow;
  logic          Underflow;
  modport master (
    output Flush, WriteEn, DataIn, ReadEn, ClearErr,
    input  DataOut, Empty, Full, Count, Overflow, Underflow
  );
  modport slave (
    input  Flush, WriteEn, DataIn, ReadEn, ClearErr,
    output DataOut, Empty, Full, Count, Overflow, Underflow
  );
endinterface

// File: rtl/mem_reg_fifo.sv
// mem_reg_fifo: D-entry first-word-fall-through FIFO staging data-memory values
module mem_reg_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input logic           Clk,
  input logic           Reset,
  mem_reg_fifo_if.slave bus
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok, ovf, unf;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(D - 1) ? '0 : p + 1'b1;
  endfunction
  assign bus.Empty     = count == '0;
  assign bus.Full      = count == CW'(D);
  assign bus.Count     = count;
  assign bus.DataOut   = bus.Empty ? '0 : mem[rd_ptr];
  assign bus.Overflow  = ovf;
  assign bus.Underflow = unf;
  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign pop_ok  = bus.ReadEn & ~bus.Empty;
  assign push_ok = bus.WriteEn & (~bus.Full | bus.ReadEn);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (bus.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.DataIn;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  // Set wins over ClearErr; requests swallowed by Flush are not errors
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (bus.WriteEn & ~push_ok & ~bus.Flush) | (ovf & ~bus.ClearErr);
      unf <= (bus.ReadEn & ~pop_ok & ~bus.Flush) | (unf & ~bus.ClearErr);
    end
endmodule

// File: tb/tb_mem_reg_fifo.sv
// tb_mem_reg_fifo: queue-model checked bench for the D=4 and D=3 staging FIFOs
module tb_mem_reg_fifo;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 Clk = ~Clk;
  mem_reg_fifo_if #(.W(8), .D(4)) a ();
  mem_reg_fifo_if #(.W(8), .D(3)) b ();
  mem_reg_fifo #(.W(8), .D(4)) dut_a (.Clk(Clk), .Reset(Reset), .bus(a.slave));
  mem_reg_fifo #(.W(8), .D(3)) dut_b (.Clk(Clk), .Reset(Reset), .bus(b.slave));
  logic [7:0] q [2][$];
  bit         m_ovf [2];
  bit         m_unf [2];
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input int k, input int dep, input logic we, input logic re,
                      input logic fl, input logic ce, input logic [7:0] din);
    bit pop, push;
    pop  = re && q[k].size() > 0;
    push = we && (q[k].size() < dep || re);
    m_ovf[k] = (we && !push && !fl) || (m_ovf[k] && !ce);
    m_unf[k] = (re && !pop && !fl) || (m_unf[k] && !ce);
    if (fl) q[k].delete();
    else begin
      if (pop) void'(q[k].pop_front());
      if (push) q[k].push_back(din);
    end
  endtask
  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      q[0].delete();
      q[1].delete();
      m_ovf = '{0, 0};
      m_unf = '{0, 0};
    end else begin
      step(0, 4, a.WriteEn, a.ReadEn, a.Flush, a.ClearErr, a.DataIn);
      step(1, 3, b.WriteEn, b.ReadEn, b.Flush, b.ClearErr, b.DataIn);
    end
  always @(negedge Clk)
    if (!Reset) begin
      check("a_count", a.Count, q[0].size());
      check("a_empty", a.Empty, q[0].size() == 0);
      check("a_full", a.Full, q[0].size() == 4);
      check("a_dout", a.DataOut, q[0].size() > 0 ? q[0][0] : 8'h00);
      check("a_ovf", a.Overflow, m_ovf[0]);
      check("a_unf", a.Underflow, m_unf[0]);
      check("b_count", b.Count, q[1].size());
      check("b_full", b.Full, q[1].size() == 3);
      check("b_dout", b.DataOut, q[1].size() > 0 ? q[1][0] : 8'h00);
      check("b_unf", b.Underflow, m_unf[1]);
    end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic op_a(input logic we, input logic re, input logic fl, input logic ce,
                      input logic [7:0] d);
    a.WriteEn = we; a.ReadEn = re; a.Flush = fl; a.ClearErr = ce; a.DataIn = d;
    tick();
    a.WriteEn = 0; a.ReadEn = 0; a.Flush = 0; a.ClearErr = 0; a.DataIn = 0;
  endtask
  task automatic op_b(input logic we, input logic re, input logic [7:0] d);
    b.WriteEn = we; b.ReadEn = re; b.DataIn = d;
    tick();
    b.WriteEn = 0; b.ReadEn = 0; b.DataIn = 0;
  endtask
  initial begin
    a.WriteEn = 0; a.ReadEn = 0; a.Flush = 0; a.ClearErr = 0; a.DataIn = 0;
    b.WriteEn = 0; b.ReadEn = 0; b.Flush = 0; b.ClearErr = 0; b.DataIn = 0;
    #1 Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("rst_count", a.Count, 0);
    check("rst_empty", a.Empty, 1);
    check("rst_full", a.Full, 0);
    check("rst_dout", a.DataOut, 0);
    check("rst_flags", {a.Overflow, a.Underflow}, 0);
    for (int i = 1; i <= 4; i++) op_a(1, 0, 0, 0, 8'(8'h11 * i));
    check("fill_full", a.Full, 1);
    check("fill_count", a.Count, 4);
    check("fill_head", a.DataOut, 8'h11);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", a.DataOut, 8'(8'h11 * i));
      op_a(0, 1, 0, 0, 0);
    end
    check("drain_empty", a.Empty, 1);
    for (int i = 1; i <= 4; i++) op_a(1, 0, 0, 0, 8'(8'h11 * i));
    op_a(1, 0, 0, 0, 8'h55);
    check("ovf_set", a.Overflow, 1);
    check("ovf_count", a.Count, 4);
    op_a(0, 0, 0, 1, 0);
    check("ovf_clr", a.Overflow, 0);
    op_a(1, 1, 0, 0, 8'h55);
    check("fullpp_head", a.DataOut, 8'h22);
    check("fullpp_count", a.Count, 4);
    check("fullpp_ovf", a.Overflow, 0);
    for (int i = 0; i < 4; i++) op_a(0, 1, 0, 0, 0);
    op_a(1, 1, 0, 0, 8'h77);
    check("nobypass_count", a.Count, 1);
    check("nobypass_dout", a.DataOut, 8'h77);
    check("nobypass_unf", a.Underflow, 1);
    op_a(0, 0, 0, 1, 0);
    check("unf_clr", a.Underflow, 0);
    op_a(0, 1, 0, 0, 0);
    op_a(0, 1, 0, 0, 0);
    op_a(0, 1, 0, 1, 0);
    check("set_wins", a.Underflow, 1);
    op_a(0, 0, 0, 1, 0);
    check("set_wins_clr", a.Underflow, 0);
    op_b(1, 0, 8'hA0);
    for (int i = 1; i <= 7; i++) begin
      op_b(1, 1, 8'(8'hA0 + i));
      check("wrap_count", b.Count, 1);
      check("wrap_head", b.DataOut, 8'(8'hA0 + i));
    end
    op_b(0, 1, 0);
    check("wrap_empty", b.Empty, 1);
    for (int i = 0; i < 3; i++) op_a(1, 0, 0, 0, 8'(8'hC0 + i));
    check("pre_flush", a.Count, 3);
    op_a(1, 0, 1, 0, 8'hEE);
    check("flush_count", a.Count, 0);
    check("flush_empty", a.Empty, 1);
    check("flush_flags", {a.Overflow, a.Underflow}, 0);
    op_a(1, 0, 0, 0, 8'h9A);
    check("post_flush_head", a.DataOut, 8'h9A);
    op_a(1, 0, 0, 0, 8'h9B);
    op_a(0, 1, 0, 0, 0);
    op_a(0, 1, 0, 0, 0);
    op_a(0, 1, 0, 0, 0);
    op_a(1, 0, 0, 0, 8'h3C);
    op_a(1, 0, 0, 0, 8'h3D);
    check("pre_rst_count", a.Count, 2);
    check("pre_rst_unf", a.Underflow, 1);
    #1 Reset = 1'b1;
    #1;
    check("async_count", a.Count, 0);
    check("async_empty", a.Empty, 1);
    check("async_dout", a.DataOut, 0);
    check("async_unf", a.Underflow, 0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
